cp2_rx_fifo: RTL and testbench
==============================

CP2_RX_FIFO -- requirements
Module: cp2_rx_fifo

Interface
REQ-001 The block SHALL have parameter DEPTH, default 8, number of 32-bit entries (power of two, >= 2).
REQ-002 The block SHALL have parameter AW, default 3, pointer width, equal to log2(DEPTH).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state SHALL change on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port cp2_tdata_0, input, 32 bits: CP2 channel-0 write data from the MEM stage.
REQ-006 The block SHALL have port cp2_tds_0, input, 1 bit: CP2 channel-0 write strobe, one word per cycle.
REQ-007 The block SHALL have port cp2_full_0, output, 1 bit: no free entry; the pipeline uses it as a stall source.
REQ-008 The block SHALL have port rx_data, output, 32 bits: head-of-queue word.
REQ-009 The block SHALL have port rx_valid, output, 1 bit: rx_data holds a valid word.
REQ-010 The block SHALL have port rx_ready, input, 1 bit: the consumer accepts rx_data.
REQ-011 The block SHALL have port rx_count, output, AW+1 bits: current occupancy, 0..DEPTH.
REQ-012 The block SHALL have port overflow, output, 1 bit: sticky dropped-write flag (see Configuration).
REQ-013 The block SHALL have port overflow_clr, input, 1 bit: clears overflow.

Function
REQ-014 Push SHALL occur when cp2_tds_0=1 and either rx_count<DEPTH, or rx_count=DEPTH with a pop in the same cycle.
REQ-015 Pop SHALL occur when rx_valid=1 and rx_ready=1.
REQ-016 A push SHALL write cp2_tdata_0 to mem[wr_ptr] and then advance wr_ptr modulo DEPTH.
REQ-017 A pop SHALL advance rd_ptr modulo DEPTH.
REQ-018 rx_count SHALL update by the following rules: +1 on push only, -1 on pop only, unchanged on simultaneous push and pop or on neither.
REQ-019 The block SHALL be first-word fall-through: rx_data SHALL equal mem[rd_ptr] combinationally from registered state.
REQ-020 rx_valid SHALL equal (rx_count != 0).
REQ-021 There SHALL be no empty bypass: a word pushed into an empty FIFO SHALL appear on rx_valid/rx_data on the next cycle (latency 1).
REQ-022 cp2_full_0 SHALL equal (rx_count == DEPTH) and SHALL be driven from registers only.
REQ-023 When full, cp2_tds_0=1 and no pop occurs, the word SHALL be dropped and no storage, pointer or count SHALL change.
REQ-024 rx_data SHALL be don't-care while rx_valid=0; verification SHALL NOT check it then.
REQ-025 When rx_ready=1 and rx_valid=0, no state SHALL change.

Reset
REQ-026 While reset=1, wr_ptr, rd_ptr and rx_count SHALL be 0, rx_valid SHALL be 0, cp2_full_0 SHALL be 0 and overflow SHALL be 0, asynchronously.
REQ-027 Storage contents SHALL NOT be reset.
REQ-028 A reset asserted mid-transfer SHALL discard all queued words.
REQ-029 The first push after reset deassertion SHALL be accepted on the first rising edge at which reset=0.

Configuration
REQ-030 With macro CP2_RX_OVERFLOW_FLAG_EN defined, overflow SHALL be set on the edge following a dropped write (REQ-023).
REQ-031 With the macro defined, overflow SHALL be cleared by overflow_clr=1.
REQ-032 With the macro defined, set SHALL win when a drop and overflow_clr=1 coincide.
REQ-033 With the macro undefined, overflow SHALL be tied to 0, overflow_clr SHALL be ignored, and no flag register SHALL be built.
REQ-034 All other behaviour SHALL be identical with and without the macro.

Verification
REQ-035 The bench SHALL cover: after reset, push 0xDEADBEEF with rx_ready=0 -> next cycle rx_valid=1, rx_data=0xDEADBEEF, rx_count=1.
REQ-036 The bench SHALL cover: push 8 words 0x1..0x8 (DEPTH=8) -> cp2_full_0=1, rx_count=8; then pop all 8 -> data 0x1..0x8 in order, final rx_count=0, rx_valid=0.
REQ-037 The bench SHALL cover: when full, push 0x99 with rx_ready=1 -> 0x1 popped, 0x99 stored last, rx_count stays 8, overflow stays 0.
REQ-038 The bench SHALL cover: when full, push 0xAA with rx_ready=0 -> word dropped, rx_count=8, overflow=1 next cycle (macro defined) or 0 (undefined); overflow_clr=1 -> overflow=0.
REQ-039 The bench SHALL cover: 20 consecutive push+pop cycles starting at rx_count=3 -> pointers wrap, rx_count stays 3, output sequence is 0x0..0x13 preserved.
REQ-040 The bench SHALL cover: assert reset with rx_count=5 between clock edges -> rx_count=0, rx_valid=0, cp2_full_0=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/cp2_rx_fifo.sv
// cp2_rx_fifo: first-word fall-through receive queue for CP2 channel-0 writes.
//
// Words written by the MEM stage (cp2_tdata_0 / cp2_tds_0) are queued.
// They are presented head-first on rx_data / rx_valid, and the consumer
// takes a word with rx_ready. A word pushed into an empty queue becomes
// visible one cycle later, because there is no empty bypass.
//
// Ports:
//   clk           single clock; all state changes on its rising edge
//   reset         asynchronous, active-high
//   cp2_tdata_0   [31:0] write data
//   cp2_tds_0     write strobe, one word per cycle
//   cp2_full_0    registered full indication (pipeline stall source)
//   rx_data       [31:0] head-of-queue word (don't-care while rx_valid=0)
//   rx_valid      queue not empty
//   rx_ready      consumer accepts rx_data
//   rx_count      [AW:0] occupancy, 0..DEPTH
//   overflow      sticky dropped-write flag
//   overflow_clr  clears overflow
//
// Optional feature: define CP2_RX_OVERFLOW_FLAG_EN to build the sticky
// overflow register. Without it, overflow is tied low and overflow_clr
// is ignored.

module cp2_rx_fifo #(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [31:0]   cp2_tdata_0,
  input  logic          cp2_tds_0,
  output logic          cp2_full_0,
  output logic [31:0]   rx_data,
  output logic          rx_valid,
  input  logic          rx_ready,
  output logic [AW:0]   rx_count,
  output logic          overflow,
  input  logic          overflow_clr
);

  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count_q;
  logic [AW:0]   count_nxt;
  logic          full_q;
  logic          pop;
  logic          push;
  logic          drop;

  // A full queue still accepts a write when a pop frees a slot in the same cycle.
  assign pop  = (count_q != '0) && rx_ready;
  assign push = cp2_tds_0 && (!full_q || pop);
  assign drop = cp2_tds_0 && full_q && !pop;

  always_comb begin
    count_nxt = count_q;
    if (push && !pop)
      count_nxt = count_q + 1'b1;
    else if (pop && !push)
      count_nxt = count_q - 1'b1;
  end

  // Pointer wrap modulo DEPTH relies on DEPTH being a power of two.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      full_q  <= 1'b0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      count_q <= count_nxt;
      full_q  <= (count_nxt == DEPTH_C);
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= cp2_tdata_0;
  end

  assign rx_data    = mem[rd_ptr];
  assign rx_valid   = (count_q != '0);
  assign rx_count   = count_q;
  assign cp2_full_0 = full_q;

`ifdef CP2_RX_OVERFLOW_FLAG_EN
  logic overflow_q;

  // Set has priority over clear when a drop and a clear coincide.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      overflow_q <= 1'b0;
    else if (drop)
      overflow_q <= 1'b1;
    else if (overflow_clr)
      overflow_q <= 1'b0;
  end

  assign overflow = overflow_q;
`else
  logic unused_ovf;

  assign unused_ovf = overflow_clr ^ drop;
  assign overflow   = 1'b0;
`endif

endmodule

// File: tb/tb_cp2_rx_fifo.sv
// Testbench for cp2_rx_fifo (DEPTH=8).
// A queue-based reference model predicts pushes, pops, occupancy and the
// overflow flag. Each scenario task compares the DUT against that model.

module tb_cp2_rx_fifo;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] cp2_tdata_0;
  logic        cp2_tds_0;
  logic        cp2_full_0;
  logic [31:0] rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [3:0]  rx_count;
  logic        overflow;
  logic        overflow_clr;

  int unsigned total = 0;
  int unsigned bad   = 0;

  logic [31:0] sb_q[$];
  logic        ovf_m;
  logic        exp_popped;
  logic [31:0] exp_word;
  logic        got_popped;
  logic [31:0] got_word;

  cp2_rx_fifo #(.DEPTH(8), .AW(3)) dut (
    .clk(clk), .reset(reset),
    .cp2_tdata_0(cp2_tdata_0), .cp2_tds_0(cp2_tds_0), .cp2_full_0(cp2_full_0),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .rx_count(rx_count), .overflow(overflow), .overflow_clr(overflow_clr)
  );

  always #5 clk = ~clk;

  // Drive one cycle, starting 1 ns after a rising edge and ending 1 ns after the next.
  task automatic cycle(input logic tds, input logic [31:0] data, input logic rdy, input logic clr);
    logic do_pop;
    logic do_push;
    cp2_tds_0    = tds;
    cp2_tdata_0  = data;
    rx_ready     = rdy;
    overflow_clr = clr;
    #1;
    got_popped = rx_valid && rx_ready;
    got_word   = rx_data;
    do_pop     = (sb_q.size() != 0) && rdy;
    do_push    = tds && ((sb_q.size() < 8) || do_pop);
    exp_popped = do_pop;
    exp_word   = do_pop ? sb_q.pop_front() : 32'h0;
    if (do_push)
      sb_q.push_back(data);
`ifdef CP2_RX_OVERFLOW_FLAG_EN
    if (tds && !do_push)
      ovf_m = 1'b1;
    else if (clr)
      ovf_m = 1'b0;
`endif
    @(posedge clk);
    #1;
    cp2_tds_0    = 1'b0;
    rx_ready     = 1'b0;
    overflow_clr = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    cp2_tds_0 = 1'b0; cp2_tdata_0 = '0; rx_ready = 1'b0; overflow_clr = 1'b0;
    ovf_m = 1'b0;
    sb_q.delete();
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({rx_count, rx_valid, cp2_full_0, overflow} !== 7'b0) begin
      bad++;
      $display("FAIL reset_state got cnt=%0d v=%b f=%b o=%b want all 0", rx_count, rx_valid, cp2_full_0, overflow);
    end
    reset = 1'b0;
  endtask

  task automatic test_single;
    cycle(1'b1, 32'hDEADBEEF, 1'b0, 1'b0);
    total++;
    if (rx_valid !== 1'b1 || rx_data !== 32'hDEADBEEF || rx_count !== 4'd1) begin
      bad++;
      $display("FAIL single_push got v=%b d=%h c=%0d want v=1 d=deadbeef c=1", rx_valid, rx_data, rx_count);
    end
    cycle(1'b0, 32'h0, 1'b1, 1'b0);
    total++;
    if (got_popped !== exp_popped || got_word !== exp_word || rx_count !== 4'd0) begin
      bad++;
      $display("FAIL single_pop got p=%b d=%h c=%0d want p=%b d=%h c=0", got_popped, got_word, rx_count, exp_popped, exp_word);
    end
  endtask

  task automatic fill(input logic [31:0] base);
    for (int i = 0; i < 8; i++)
      cycle(1'b1, base + 32'(i), 1'b0, 1'b0);
  endtask

  task automatic drain(input string tag);
    int n;
    n = sb_q.size();
    for (int i = 0; i < n; i++) begin
      cycle(1'b0, 32'h0, 1'b1, 1'b0);
      total++;
      if (got_popped !== 1'b1 || got_word !== exp_word) begin
        bad++;
        $display("FAIL %s_pop%0d got p=%b d=%h want p=1 d=%h", tag, i, got_popped, got_word, exp_word);
      end
    end
    total++;
    if (rx_count !== 4'd0 || rx_valid !== 1'b0 || cp2_full_0 !== 1'b0) begin
      bad++;
      $display("FAIL %s_empty got c=%0d v=%b f=%b want 0 0 0", tag, rx_count, rx_valid, cp2_full_0);
    end
  endtask

  task automatic test_fill_drain;
    fill(32'h1);
    total++;
    if (cp2_full_0 !== 1'b1 || rx_count !== 4'd8) begin
      bad++;
      $display("FAIL fill_full got f=%b c=%0d want f=1 c=8", cp2_full_0, rx_count);
    end
    drain("fill");
  endtask

  task automatic test_full_push_pop;
    fill(32'h1);
    cycle(1'b1, 32'h99, 1'b1, 1'b0);
    total++;
    if (got_word !== 32'h1 || exp_word !== 32'h1 || rx_count !== 4'd8 || cp2_full_0 !== 1'b1 || overflow !== 1'b0) begin
      bad++;
      $display("FAIL full_pushpop got d=%h c=%0d f=%b o=%b want d=1 c=8 f=1 o=0", got_word, rx_count, cp2_full_0, overflow);
    end
  endtask

  task automatic test_overflow;
    // Still full from the previous scenario.
    cycle(1'b1, 32'hAA, 1'b0, 1'b0);
    total++;
    if (rx_count !== 4'd8 || overflow !== ovf_m || sb_q.size() != 8) begin
      bad++;
      $display("FAIL drop got c=%0d o=%b want c=8 o=%b", rx_count, overflow, ovf_m);
    end
    cycle(1'b0, 32'h0, 1'b0, 1'b1);
    total++;
    if (overflow !== 1'b0) begin
      bad++;
      $display("FAIL ovf_clr got o=%b want 0", overflow);
    end
    // A drop and a clear in the same cycle: the drop wins.
    cycle(1'b1, 32'hBB, 1'b0, 1'b1);
    total++;
    if (overflow !== ovf_m || rx_count !== 4'd8) begin
      bad++;
      $display("FAIL drop_vs_clr got o=%b c=%0d want o=%b c=8", overflow, rx_count, ovf_m);
    end
    cycle(1'b0, 32'h0, 1'b0, 1'b1);
    drain("ovf");
  endtask

  task automatic test_back_to_back;
    for (int i = 0; i < 3; i++)
      cycle(1'b1, 32'(i), 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      cycle(1'b1, 32'(i + 3), 1'b1, 1'b0);
      total++;
      if (got_popped !== 1'b1 || got_word !== exp_word || got_word !== 32'(i) || rx_count !== 4'd3) begin
        bad++;
        $display("FAIL b2b%0d got d=%h c=%0d want d=%h c=3", i, got_word, rx_count, exp_word);
      end
    end
    drain("b2b");
  endtask

  task automatic test_async_reset;
    for (int i = 0; i < 5; i++)
      cycle(1'b1, 32'h50 + 32'(i), 1'b0, 1'b0);
    total++;
    if (rx_count !== 4'd5) begin
      bad++;
      $display("FAIL pre_reset got c=%0d want 5", rx_count);
    end
    #2;
    reset = 1'b1;
    #1;
    sb_q.delete();
    ovf_m = 1'b0;
    total++;
    if (rx_count !== 4'd0 || rx_valid !== 1'b0 || cp2_full_0 !== 1'b0) begin
      bad++;
      $display("FAIL async_reset got c=%0d v=%b f=%b want 0 0 0", rx_count, rx_valid, cp2_full_0);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    cycle(1'b1, 32'h77, 1'b0, 1'b0);
    total++;
    if (rx_count !== 4'd1 || rx_data !== 32'h77) begin
      bad++;
      $display("FAIL post_reset_push got c=%0d d=%h want c=1 d=77", rx_count, rx_data);
    end
    drain("rst");
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill_drain();
    test_full_push_pop();
    test_overflow();
    test_back_to_back();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
